// File: rtl/regfile_writeback.sv
// Register-file writeback: arbitrates single-cycle ALU results against a small
// load-result FIFO and drives one registered write per cycle, dropping writes to r0.
module regfile_writeback #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int MEM_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           alu_valid,
    input  logic [ADDR_W-1:0]              alu_rd,
    input  logic [DATA_W-1:0]              alu_data,
    input  logic                           mem_valid,
    output logic                           mem_ready,
    input  logic [ADDR_W-1:0]              mem_rd,
    input  logic [DATA_W-1:0]              mem_data,
    input  logic                           flush,
    output logic                           reg_write,
    output logic [ADDR_W-1:0]              write_reg,
    output logic [DATA_W-1:0]              write_data,
    output logic [$clog2(MEM_DEPTH):0]     mem_count
);

    localparam int PTR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] fifo_data_r [MEM_DEPTH];
    logic [ADDR_W-1:0] fifo_rd_r   [MEM_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              reg_write_r;
    logic [ADDR_W-1:0] write_reg_r;
    logic [DATA_W-1:0] write_data_r;

    logic              alu_sel_s;
    logic              push_s;
    logic              pop_s;
    logic              wr_sel_s;
    logic [ADDR_W-1:0] sel_reg_s;
    logic [DATA_W-1:0] sel_data_s;

    // Readiness looks only at current occupancy, so a same-cycle pop never frees a slot.
    assign mem_ready  = (count_r != CNT_W'(MEM_DEPTH));
    assign mem_count  = count_r;
    assign reg_write  = reg_write_r;
    assign write_reg  = write_reg_r;
    assign write_data = write_data_r;

    // Source arbitration: ALU first, then FIFO head; r0 loads handshake but are never stored.
    always_comb begin
        alu_sel_s  = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        wr_sel_s   = 1'b0;
        sel_reg_s  = write_reg_r;
        sel_data_s = write_data_r;

        alu_sel_s = alu_valid && (alu_rd != {ADDR_W{1'b0}});
        push_s    = mem_valid && mem_ready && (mem_rd != {ADDR_W{1'b0}}) && !flush;
        pop_s     = !alu_sel_s && (count_r != {CNT_W{1'b0}}) && !flush;
        wr_sel_s  = alu_sel_s || pop_s;

        if (alu_sel_s) begin
            sel_reg_s  = alu_rd;
            sel_data_s = alu_data;
        end else if (pop_s) begin
            sel_reg_s  = fifo_rd_r[rd_ptr_r];
            sel_data_s = fifo_data_r[rd_ptr_r];
        end else begin
            sel_reg_s  = write_reg_r;
            sel_data_s = write_data_r;
        end
    end

    // FIFO pointers and occupancy; flush wins over any push or pop on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= mem_data;
            fifo_rd_r[wr_ptr_r]   <= mem_rd;
        end
    end

    // Registered write port: enable every edge, address/data only when a write is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= {ADDR_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
        end else begin
            reg_write_r  <= wr_sel_s;
            write_reg_r  <= sel_reg_s;
            write_data_r <= sel_data_s;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed stimulus queues expected writes,
// a negedge monitor pops and compares every observed register-file write.
module tb_regfile_writeback;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        flush;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [2:0]  mem_count;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    regfile_writeback #(.DATA_W(32), .ADDR_W(5), .MEM_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .flush      (flush),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .mem_count  (mem_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_data  = 32'd0;
        flush     = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 0) break;
            cyc();
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (4) cyc();
    endtask

    // Monitor: every write presented to the register file must match the queue head.
    always @(negedge clk) begin
        if (rst_n && reg_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_reg", {27'd0, write_reg}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_reg", {27'd0, write_reg}, {27'd0, e.rd});
                check("write_data", write_data, e.data);
            end
        end
    end

    initial begin
        // Reset with traffic on the inputs
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h33;
        mem_valid = 1'b1;
        mem_rd    = 5'd4;
        mem_data  = 32'h44;
        flush     = 1'b0;
        repeat (3) cyc();
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_mem_count", {29'd0, mem_count}, 32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        idle();
        rst_n = 1'b1;
        repeat (2) cyc();
        check("idle_reg_write", {31'd0, reg_write}, 32'd0);
        check("idle_write_reg", {27'd0, write_reg}, 32'd0);
        check("idle_write_data", write_data, 32'd0);
        check("idle_mem_count", {29'd0, mem_count}, 32'd0);
        check("idle_mem_ready", {31'd0, mem_ready}, 32'd1);

        // ALU streaming, then an r0 result
        expect_wr(5'd1, 32'hA);
        expect_wr(5'd2, 32'hB);
        expect_wr(5'd3, 32'hC);
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
        cyc();
        check("alu_lat_reg_write", {31'd0, reg_write}, 32'd1);
        check("alu_lat_write_reg", {27'd0, write_reg}, 32'd1);
        alu_rd = 5'd2; alu_data = 32'hB;
        cyc();
        check("alu_b2b_reg_write", {31'd0, reg_write}, 32'd1);
        alu_rd = 5'd3; alu_data = 32'hC;
        cyc();
        check("alu_b2b3_reg_write", {31'd0, reg_write}, 32'd1);
        alu_rd = 5'd0; alu_data = 32'h5;
        cyc();
        check("alu_r0_reg_write", {31'd0, reg_write}, 32'd0);
        check("alu_r0_hold_reg", {27'd0, write_reg}, 32'd3);
        check("alu_r0_hold_data", write_data, 32'hC);
        idle();
        wait_drain();

        // Load contention: ALU r7,r8,r9 win, loads r5,r6 follow in order
        expect_wr(5'd7, 32'h70);
        expect_wr(5'd8, 32'h80);
        expect_wr(5'd9, 32'h90);
        expect_wr(5'd5, 32'h55);
        expect_wr(5'd6, 32'h66);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h55;
        cyc();
        alu_rd = 5'd8; alu_data = 32'h80;
        mem_rd = 5'd6; mem_data = 32'h66;
        cyc();
        alu_rd = 5'd9; alu_data = 32'h90;
        mem_valid = 1'b0;
        cyc();
        check("contend_mem_count", {29'd0, mem_count}, 32'd2);
        idle();
        wait_drain();
        check("contend_drained", {29'd0, mem_count}, 32'd0);

        // FIFO full under continuous ALU traffic
        for (int i = 0; i < 6; i++) expect_wr(5'(10 + i), 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) expect_wr(5'(16 + i), 32'h1010 + 32'(i));
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h100 + 32'(i);
            mem_valid = 1'b1; mem_rd = 5'(16 + i); mem_data = 32'h1010 + 32'(i);
            cyc();
        end
        check("full_mem_count", {29'd0, mem_count}, 32'd4);
        check("full_mem_ready", {31'd0, mem_ready}, 32'd0);
        alu_valid = 1'b0;
        mem_rd = 5'd20; mem_data = 32'h2020;
        cyc();
        check("full_pop_no_push", {29'd0, mem_count}, 32'd3);
        check("full_ready_after_pop", {31'd0, mem_ready}, 32'd1);
        idle();
        wait_drain();

        // rd=0 ALU result does not block a FIFO pop
        expect_wr(5'd13, 32'h130);
        expect_wr(5'd12, 32'h120);
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h130;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h120;
        cyc();
        alu_rd = 5'd0; alu_data = 32'hBAD;
        mem_valid = 1'b0;
        cyc();
        check("r0alu_pop_write", {31'd0, reg_write}, 32'd1);
        check("r0alu_pop_reg", {27'd0, write_reg}, 32'd12);
        idle();
        wait_drain();

        // Flush with 3 buffered loads, concurrent ALU r9 and a load offer
        for (int i = 0; i < 3; i++) expect_wr(5'(1 + i), 32'h201 + 32'(i));
        expect_wr(5'd9, 32'h999);
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'h201 + 32'(i);
            mem_valid = 1'b1; mem_rd = 5'(21 + i); mem_data = 32'h2100 + 32'(i);
            cyc();
        end
        check("preflush_mem_count", {29'd0, mem_count}, 32'd3);
        flush = 1'b1;
        alu_rd = 5'd9; alu_data = 32'h999;
        mem_rd = 5'd24; mem_data = 32'h2400;
        cyc();
        check("flush_mem_count", {29'd0, mem_count}, 32'd0);
        check("flush_alu_reg", {27'd0, write_reg}, 32'd9);
        idle();
        wait_drain();

        // Load to r0: handshake only
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD;
        check("r0load_ready", {31'd0, mem_ready}, 32'd1);
        cyc();
        mem_valid = 1'b0;
        check("r0load_count", {29'd0, mem_count}, 32'd0);
        cyc();
        check("r0load_no_write", {31'd0, reg_write}, 32'd0);
        idle();
        wait_drain();

        // Reset mid-operation clears outputs without a clock edge and loses buffered loads
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        mem_valid = 1'b1; mem_rd = 5'd14; mem_data = 32'h1414;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("async_rst_write_reg", {27'd0, write_reg}, 32'd0);
        check("async_rst_mem_count", {29'd0, mem_count}, 32'd0);
        idle();
        cyc();
        rst_n = 1'b1;
        wait_drain();
        check("post_rst_mem_count", {29'd0, mem_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
